// File: rtl/busca_aproximacao_sucessiva.sv
// Successive-approximation search controller: drives candidate B into an external
// magnitude comparator and resolves the hidden operand A MSB first.
module busca_aproximacao_sucessiva #(
  parameter int N = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         iniciar,
  input  logic         igual,
  input  logic         maior,
  input  logic         menor,
  output logic [N-1:0] B,
  output logic [N-1:0] resultado,
  output logic         pronto,
  output logic         erro,
  output logic         ocupado
);

  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam logic [N-1:0] MSB_ONLY = {1'b1, {(N-1){1'b0}}};
  localparam logic [KW-1:0] K_TOP = KW'(N - 1);

  typedef enum logic {
    OCIOSO,
    TESTA
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [KW-1:0] r_k, w_k_nxt;
  logic [N-1:0]  r_b, w_b_nxt;
  logic [N-1:0]  r_res, w_res_nxt;
  logic          r_pronto, w_pronto_nxt;
  logic          r_erro, w_erro_nxt;
  logic          r_ocupado, w_ocupado_nxt;
  logic [N-1:0]  w_mask;
  logic [N-1:0]  w_cand;
  logic          w_onehot;

  always_comb begin
    w_onehot = 1'b0;
    case ({igual, maior, menor})
      3'b100, 3'b010, 3'b001: w_onehot = 1'b1;
      default:                w_onehot = 1'b0;
    endcase
  end

  // Bit under test; "menor" means the tentative bit overshoots A and must drop.
  always_comb begin
    w_mask = N'(1) << r_k;
    w_cand = menor ? (r_b & ~w_mask) : r_b;
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_k_nxt       = r_k;
    w_b_nxt       = r_b;
    w_res_nxt     = r_res;
    w_pronto_nxt  = 1'b0;
    w_erro_nxt    = 1'b0;
    w_ocupado_nxt = r_ocupado;
    case (r_state)
      OCIOSO: begin
        if (iniciar) begin
          w_state_nxt   = TESTA;
          w_b_nxt       = MSB_ONLY;
          w_k_nxt       = K_TOP;
          w_ocupado_nxt = 1'b1;
        end
      end
      TESTA: begin
        if (!w_onehot) begin
          w_state_nxt   = OCIOSO;
          w_erro_nxt    = 1'b1;
          w_pronto_nxt  = 1'b1;
          w_res_nxt     = '0;
          w_b_nxt       = '0;
          w_ocupado_nxt = 1'b0;
        end else if (igual) begin
          w_state_nxt   = OCIOSO;
          w_res_nxt     = r_b;
          w_pronto_nxt  = 1'b1;
          w_ocupado_nxt = 1'b0;
        end else if (r_k == '0) begin
          w_state_nxt   = OCIOSO;
          w_res_nxt     = w_cand;
          w_pronto_nxt  = 1'b1;
          w_ocupado_nxt = 1'b0;
        end else begin
          w_b_nxt = w_cand | (w_mask >> 1);
          w_k_nxt = r_k - 1'b1;
        end
      end
      default: w_state_nxt = OCIOSO;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= OCIOSO;
      r_k       <= K_TOP;
      r_b       <= '0;
      r_res     <= '0;
      r_pronto  <= 1'b0;
      r_erro    <= 1'b0;
      r_ocupado <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_k       <= w_k_nxt;
      r_b       <= w_b_nxt;
      r_res     <= w_res_nxt;
      r_pronto  <= w_pronto_nxt;
      r_erro    <= w_erro_nxt;
      r_ocupado <= w_ocupado_nxt;
    end
  end

  assign B         = r_b;
  assign resultado = r_res;
  assign pronto    = r_pronto;
  assign erro      = r_erro;
  assign ocupado   = r_ocupado;

endmodule

// File: tb/tb_busca_aproximacao_sucessiva.sv
// Bench for busca_aproximacao_sucessiva: behavioural comparator + search model,
// per-cycle output comparison, plus literal scenario checks.
module tb_busca_aproximacao_sucessiva;
  localparam int N = 4;

  logic         clock = 1'b0;
  logic         reset;
  logic         iniciar;
  logic         igual, maior, menor;
  logic [N-1:0] B, resultado;
  logic         pronto, erro, ocupado;

  logic [N-1:0] A;
  logic         f_force;
  logic [2:0]   f_val;

  int n_checks = 0;
  int n_errors = 0;

  assign igual = f_force ? f_val[2] : (A == B);
  assign maior = f_force ? f_val[1] : (A > B);
  assign menor = f_force ? f_val[0] : (A < B);

  always #5 clock = ~clock;

  busca_aproximacao_sucessiva #(.N(N)) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar),
    .igual(igual), .maior(maior), .menor(menor),
    .B(B), .resultado(resultado), .pronto(pronto), .erro(erro), .ocupado(ocupado)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  // Value probed at step s: the already-known top s bits of A, then a trial 1.
  function automatic logic [N-1:0] probe(input logic [N-1:0] a, input int s);
    logic [N-1:0] hi;
    hi = (s == 0) ? '0 : ((a >> (N - s)) << (N - s));
    return hi | (N'(1) << (N - 1 - s));
  endfunction

  logic         m_busy = 1'b0, m_pronto = 1'b0, m_erro = 1'b0;
  logic [N-1:0] m_B = '0, m_res = '0;
  int           m_step = 0;
  logic [2:0]   m_fl;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_busy = 0; m_pronto = 0; m_erro = 0; m_B = '0; m_res = '0; m_step = 0;
    end else if (!m_busy) begin
      m_pronto = 0; m_erro = 0;
      if (iniciar) begin
        m_busy = 1; m_step = 0; m_B = probe(A, 0);
      end
    end else begin
      m_fl = f_force ? f_val : {A == m_B, A > m_B, A < m_B};
      if ($countones(m_fl) != 1) begin
        m_erro = 1; m_pronto = 1; m_res = '0; m_B = '0; m_busy = 0;
      end else if (m_fl[2] || m_step == N - 1) begin
        m_res = A; m_pronto = 1; m_busy = 0;
      end else begin
        m_step++;
        m_B = probe(A, m_step);
      end
    end
  end

  always @(negedge clock) begin
    chk("B", 32'(B), 32'(m_B));
    chk("resultado", 32'(resultado), 32'(m_res));
    chk("pronto", 32'(pronto), 32'(m_pronto));
    chk("erro", 32'(erro), 32'(m_erro));
    chk("ocupado", 32'(ocupado), 32'(m_busy));
  end

  logic [N-1:0] q_b[$];
  always @(negedge clock) if (ocupado) q_b.push_back(B);

  task automatic run_search(input logic [N-1:0] a, input bit extra_pulse, output int cyc);
    bit done;
    A = a;
    q_b.delete();
    iniciar = 1'b1;
    @(negedge clock);
    iniciar = 1'b0;
    done = 0;
    for (int t = 0; t < 3 * N && !done; t++) begin
      iniciar = extra_pulse && (t == 0);
      @(negedge clock);
      if (pronto) done = 1;
    end
    iniciar = 1'b0;
    if (!done) chk("search_timeout", 0, 1);
    cyc = q_b.size();
  endtask

  task automatic wait_pronto(input string name);
    bit done;
    done = 0;
    for (int t = 0; t < 3 * N && !done; t++) begin
      @(negedge clock);
      if (pronto) done = 1;
    end
    if (!done) chk(name, 0, 1);
  endtask

  logic [2:0] fvals[5];
  initial begin
    int cyc;
    int fs;
    bit done;
    fvals = '{3'b000, 3'b011, 3'b101, 3'b110, 3'b111};
    reset = 1'b1; iniciar = 1'b0; A = '0; f_force = 1'b0; f_val = '0;
    repeat (2) @(negedge clock);
    chk("rst_B", 32'(B), 0);
    chk("rst_ocupado", 32'(ocupado), 0);
    chk("rst_resultado", 32'(resultado), 0);
    reset = 1'b0;
    @(negedge clock);

    run_search(4'd9, 0, cyc);
    chk("a9_cycles", cyc, 4);
    chk("a9_b0", 32'(q_b[0]), 8);
    chk("a9_b1", 32'(q_b[1]), 12);
    chk("a9_b2", 32'(q_b[2]), 10);
    chk("a9_b3", 32'(q_b[3]), 9);
    chk("a9_res", 32'(resultado), 9);
    chk("a9_erro", 32'(erro), 0);
    @(negedge clock);

    run_search(4'd0, 0, cyc);
    chk("a0_cycles", cyc, 4);
    chk("a0_b1", 32'(q_b[1]), 4);
    chk("a0_b3", 32'(q_b[3]), 1);
    chk("a0_res", 32'(resultado), 0);

    run_search(4'd8, 0, cyc);
    chk("a8_cycles", cyc, 1);
    chk("a8_res", 32'(resultado), 8);
    run_search(4'd15, 0, cyc);
    chk("a15_cycles", cyc, 4);
    chk("a15_b2", 32'(q_b[2]), 14);
    chk("a15_res", 32'(resultado), 15);

    // Not-one-hot flags on the second evaluation.
    A = 4'd6;
    iniciar = 1'b1; @(negedge clock); iniciar = 1'b0;
    @(negedge clock);
    f_force = 1'b1; f_val = 3'b011;
    @(negedge clock);
    f_force = 1'b0;
    chk("flt_pronto", 32'(pronto), 1);
    chk("flt_erro", 32'(erro), 1);
    chk("flt_res", 32'(resultado), 0);
    chk("flt_B", 32'(B), 0);
    chk("flt_ocupado", 32'(ocupado), 0);
    @(negedge clock);
    chk("flt_pulse_end", 32'(pronto), 0);

    run_search(4'd5, 1, cyc);
    chk("a5_ign_cycles", cyc, 4);
    chk("a5_ign_res", 32'(resultado), 5);
    @(negedge clock);
    chk("a5_no_restart", 32'(ocupado), 0);

    // Asynchronous abort in the second TESTA cycle.
    iniciar = 1'b1; @(negedge clock); iniciar = 1'b0;
    @(negedge clock);
    #2 reset = 1'b1;
    #1;
    chk("abort_B", 32'(B), 0);
    chk("abort_ocupado", 32'(ocupado), 0);
    chk("abort_pronto", 32'(pronto), 0);
    chk("abort_res", 32'(resultado), 0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    chk("abort_idle", 32'(ocupado), 0);
    run_search(4'd5, 0, cyc);
    chk("a5_after_rst", 32'(resultado), 5);

    // Back-to-back searches with iniciar held.
    A = 4'd3;
    iniciar = 1'b1;
    wait_pronto("b2b_timeout1");
    chk("b2b_res1", 32'(resultado), 3);
    A = 4'd12;
    @(negedge clock);
    chk("b2b_restart", 32'(ocupado), 1);
    wait_pronto("b2b_timeout2");
    iniciar = 1'b0;
    chk("b2b_res2", 32'(resultado), 12);
    @(negedge clock);

    for (int it = 0; it < 40; it++) begin
      A = N'($urandom_range(0, (1 << N) - 1));
      fs = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, N - 1)) : -1;
      iniciar = 1'b1; @(negedge clock); iniciar = 1'b0;
      done = 0;
      for (int t = 0; t < 3 * N && !done; t++) begin
        f_force = (t == fs);
        f_val = fvals[$urandom_range(0, 4)];
        @(negedge clock);
        if (pronto) done = 1;
      end
      f_force = 1'b0;
      if (!done) chk("rand_timeout", 0, 1);
      repeat ($urandom_range(0, 2)) @(negedge clock);
    end

    @(negedge clock);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
